// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the single-bus datapath
//
// Purpose: steps RST -> T0..T7 (-> HALT) from the IR opcode and drives every
//   datapath strobe, the memory Read/Write strobes and the ALU opcode.
// Ports:
//   clk, clr (sync active-high reset), ir[31:0] (opcode = ir[31:27]),
//   con_ff (branch condition), mem_ready (memory handshake, wait builds only)
//   datapath strobes: PCout PCin incPC MARin MDRin MDRout IRin Yin Zin
//                     ZLowOut ZHighOut HIin LOin
//   register select:  Gra Grb Grc Rin Rout BAout Cout CONin
//   memory:           Read Write
//   alu_op[4:0], run (high while executing, low in RST and HALT)
// Configuration macro: CU_MEM_WAIT_EN -- fetch T1, ld T6 and st T7 hold until
//   mem_ready=1. Undefined: mem_ready is ignored and memory is single-cycle.

module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        incPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  assign opcode = ir[31:27];

  // Only the opcode field steers sequencing; register fields go to the datapath.
  logic [26:0] unused_ir;
  assign unused_ir = ir[26:0];

  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_muldiv, is_br, is_halt;
  assign is_ld     = (opcode == 5'b00000);
  assign is_ldi    = (opcode == 5'b00001);
  assign is_st     = (opcode == 5'b00010);
  assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
  assign is_br     = (opcode == 5'b10011);
  assign is_halt   = (opcode == 5'b11011);

  logic is_nop;
  assign is_nop = !(is_ld || is_ldi || is_st || is_alu || is_imm ||
                    is_muldiv || is_br || is_halt);

  // mem_ok gates the memory steps; without wait support it is always true.
  logic mem_ok;
`ifdef CU_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  logic [4:0] imm_op;
  always_comb begin
    imm_op = ALU_ADD;
    if (opcode == 5'b01101) imm_op = ALU_AND;
    else if (opcode == 5'b01110) imm_op = ALU_OR;
  end

  // State register: clr wins over everything, including a memory hold.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ok) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_nop) state_d = S_T0;
        else             state_d = S_T4;
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (is_alu || is_imm || is_ldi) state_d = S_T0;
        else                            state_d = S_T6;
      end
      S_T6: begin
        if (is_ld) begin
          if (mem_ok) state_d = S_T7;
        end else if (is_st) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_st) begin
          if (mem_ok) state_d = S_T0;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Output decode from registered state and ir
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; incPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLowOut = 1'b0;
    ZHighOut = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = 5'b00000;
    run = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = imm_op;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_ld || is_ldi || is_st) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin
          ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          ZLowOut = 1'b1; LOin = 1'b1;
        end else if (is_ld || is_st) begin
          ZLowOut = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          ZHighOut = 1'b1; HIin = 1'b1;
        end else if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          // Branch target is always on the bus; only the PC load is conditional.
          ZLowOut = 1'b1; PCin = con_ff;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer

module tb_control_sequencer;

  logic clk, clr, con_ff, mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut;
  logic HIin, LOin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write, run;
  logic [4:0] alu_op;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe bit positions in the observation vector
  localparam logic [22:0] M_PCOUT = 23'd1 << 0,  M_PCIN = 23'd1 << 1,  M_INCPC = 23'd1 << 2;
  localparam logic [22:0] M_MARIN = 23'd1 << 3,  M_MDRIN = 23'd1 << 4, M_MDROUT = 23'd1 << 5;
  localparam logic [22:0] M_IRIN = 23'd1 << 6,   M_YIN = 23'd1 << 7,   M_ZIN = 23'd1 << 8;
  localparam logic [22:0] M_ZLO = 23'd1 << 9,    M_ZHI = 23'd1 << 10,  M_HIIN = 23'd1 << 11;
  localparam logic [22:0] M_LOIN = 23'd1 << 12,  M_GRA = 23'd1 << 13,  M_GRB = 23'd1 << 14;
  localparam logic [22:0] M_GRC = 23'd1 << 15,   M_RIN = 23'd1 << 16,  M_ROUT = 23'd1 << 17;
  localparam logic [22:0] M_BAOUT = 23'd1 << 18, M_COUT = 23'd1 << 19, M_CONIN = 23'd1 << 20;
  localparam logic [22:0] M_READ = 23'd1 << 21,  M_WRITE = 23'd1 << 22;

  logic [28:0] obs;
  assign obs = {run, alu_op, Write, Read, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, IRin, MDRout, MDRin, MARin,
                incPC, PCin, PCout};

  int checks = 0;
  int failures = 0;
  logic [28:0] exp_q[$];

  function automatic logic [28:0] step(logic [22:0] s, logic [4:0] a);
    return {1'b1, a, s};
  endfunction

  // Reference: the sequence of per-cycle output sets an instruction produces
  // starting at T0, with no wait states.
  function automatic void build_seq(logic [4:0] op, logic con);
    logic [4:0] immop;
    exp_q.delete();
    exp_q.push_back(step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
    exp_q.push_back(step(M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'd0));
    exp_q.push_back(step(M_MDROUT | M_IRIN, 5'd0));
    if (op >= 5'd3 && op <= 5'd11) begin
      exp_q.push_back(step(M_GRB | M_ROUT | M_YIN, 5'd0));
      exp_q.push_back(step(M_GRC | M_ROUT | M_ZIN, op));
      exp_q.push_back(step(M_ZLO | M_GRA | M_RIN, 5'd0));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      immop = (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b00101 : 5'b00110;
      exp_q.push_back(step(M_GRB | M_ROUT | M_YIN, 5'd0));
      exp_q.push_back(step(M_COUT | M_ZIN, immop));
      exp_q.push_back(step(M_ZLO | M_GRA | M_RIN, 5'd0));
    end else if (op == 5'd15 || op == 5'd16) begin
      exp_q.push_back(step(M_GRA | M_ROUT | M_YIN, 5'd0));
      exp_q.push_back(step(M_GRB | M_ROUT | M_ZIN, op));
      exp_q.push_back(step(M_ZLO | M_LOIN, 5'd0));
      exp_q.push_back(step(M_ZHI | M_HIIN, 5'd0));
    end else if (op <= 5'd2) begin
      exp_q.push_back(step(M_GRB | M_BAOUT | M_YIN, 5'd0));
      exp_q.push_back(step(M_COUT | M_ZIN, 5'b00011));
      if (op == 5'd1) begin
        exp_q.push_back(step(M_ZLO | M_GRA | M_RIN, 5'd0));
      end else begin
        exp_q.push_back(step(M_ZLO | M_MARIN, 5'd0));
        if (op == 5'd0) begin
          exp_q.push_back(step(M_READ | M_MDRIN, 5'd0));
          exp_q.push_back(step(M_MDROUT | M_GRA | M_RIN, 5'd0));
        end else begin
          exp_q.push_back(step(M_GRA | M_ROUT | M_MDRIN, 5'd0));
          exp_q.push_back(step(M_WRITE, 5'd0));
        end
      end
    end else if (op == 5'd19) begin
      exp_q.push_back(step(M_GRA | M_ROUT | M_CONIN, 5'd0));
      exp_q.push_back(step(M_PCOUT | M_YIN, 5'd0));
      exp_q.push_back(step(M_COUT | M_ZIN, 5'b00011));
      exp_q.push_back(step(M_ZLO | (con ? M_PCIN : 23'd0), 5'd0));
    end else begin
      // halt and nop both show an empty T3 (run still high)
      exp_q.push_back(step(23'd0, 5'd0));
    end
  endfunction

  // Called at a negedge while the DUT sits in T0. Checks up to max_steps
  // cycles of the instruction and returns at the following negedge.
  task automatic run_instr(input logic [4:0] op, input logic con, input int max_steps,
                           input string name);
    logic [31:0] r;
    logic mr;
    int i = 0;
    int n = 0;
    r = $urandom();
    ir = {op, r[26:0]};
    con_ff = con;
    build_seq(op, con);
    while (i < exp_q.size() && n < max_steps && n < 400) begin
      mr = ($urandom_range(0, 3) != 0);
      mem_ready = mr;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL %s op=%0d step=%0d got=%h expected=%h", name, op, i, obs, exp_q[i]);
      end
      @(negedge clk);
      n++;
`ifdef CU_MEM_WAIT_EN
      if (!(((exp_q[i][22:0] & (M_READ | M_WRITE)) != 23'd0) && !mr)) i++;
`else
      i++;
`endif
    end
    mem_ready = 1'b1;
  endtask

  task automatic check_vec(input logic [28:0] expv, input string name);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, obs, expv);
    end
  endtask

  localparam logic [28:0] V_T0 = {1'b1, 5'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN};
  localparam logic [28:0] V_T1 = {1'b1, 5'd0, M_ZLO | M_PCIN | M_READ | M_MDRIN};
  localparam logic [28:0] V_T2 = {1'b1, 5'd0, M_MDROUT | M_IRIN};

  // Ends at a negedge in T0.
  task automatic do_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check_vec(29'd0, "reset_rst");
    clr = 1'b0;
    @(negedge clk);
    check_vec(V_T0, "reset_t0");
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    run_instr(5'b00011, 1'b0, 1000, "add");
    check_vec(V_T0, "add_back_t0");
  endtask

  task automatic test_ld();
    run_instr(5'b00000, 1'b0, 1000, "ld");
    check_vec(V_T0, "ld_back_t0");
  endtask

  task automatic test_br();
    run_instr(5'b10011, 1'b0, 1000, "br_not_taken");
    run_instr(5'b10011, 1'b1, 1000, "br_taken");
    check_vec(V_T0, "br_back_t0");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int k = 0; k < 80; k++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      run_instr(op, 1'($urandom_range(0, 1)), 1000, "random");
    end
    check_vec(V_T0, "random_back_t0");
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[6] = '{5'd2, 5'd1, 5'd15, 5'd16, 5'd14, 5'd20};
    foreach (ops[k]) run_instr(ops[k], 1'b1, 1000, "b2b");
    check_vec(V_T0, "b2b_back_t0");
  endtask

  task automatic test_clr_mid();
    logic [4:0] ops[4] = '{5'd0, 5'd2, 5'd15, 5'd19};
    for (int k = 0; k < 8; k++) begin
      run_instr(ops[k % 4], 1'b1, $urandom_range(1, 6), "clr_mid_pre");
      clr = 1'b1;
      @(negedge clk);
      check_vec(29'd0, "clr_mid_rst");
      clr = 1'b0;
      @(negedge clk);
      check_vec(V_T0, "clr_mid_t0");
    end
  endtask

  task automatic test_halt();
    run_instr(5'b11011, 1'b0, 1000, "halt_fetch");
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check_vec(29'd0, "halt_hold");
      @(negedge clk);
    end
    mem_ready = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check_vec(29'd0, "halt_clr_rst");
    clr = 1'b0;
    @(negedge clk);
    check_vec(V_T0, "halt_exit_t0");
  endtask

`ifdef CU_MEM_WAIT_EN
  task automatic test_mem_wait();
    mem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_vec(V_T1, "wait_t1_hold");
      if (k == 3) mem_ready = 1'b1;
      @(negedge clk);
    end
    check_vec(V_T2, "wait_t2");
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_vec(V_T1, "wait_clr_hold");
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    check_vec(29'd0, "wait_clr_rst");
    clr = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check_vec(V_T0, "wait_clr_t0");
  endtask
`else
  task automatic test_mem_wait();
    mem_ready = 1'b0;
    @(negedge clk);
    check_vec(V_T1, "nowait_t1");
    @(negedge clk);
    check_vec(V_T2, "nowait_t2");
    mem_ready = 1'b1;
    do_reset();
  endtask
`endif

  initial begin
    clr = 1'b1;
    ir = 32'd0;
    con_ff = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_add();
    test_ld();
    test_br();
    test_back_to_back();
    test_random();
    test_clr_mid();
    test_halt();
    test_mem_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
